// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM state codes,
// owner codes and the width of the loader aging counter.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    S_ARB_IDLE   = 2'b00,
    S_ARB_ACCESS = 2'b01,
    S_ARB_RESP   = 2'b10
  } arb_state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_LDR  = 2'b10;

  // starve counter saturates at 7, so STARVE_LIMIT must stay within 1..7
  localparam int STARVE_CNT_W = 3;

endpackage

// File: rtl/dmem_port_arbiter_age_counter.sv
// Loader aging counter: counts arbitrations the loader lost to the CPU,
// saturates at all-ones, and flags when the loader is owed the next grant.
module arb_age_counter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset_cycle,
  input  logic inc_i,
  input  logic clr_i,
  output logic ge_limit_o
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  // clear wins over increment; increment stops at the saturation value
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  // counter register, cleared asynchronously
  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) cnt_q <= '0;
    else             cnt_q <= cnt_d;
  end

  assign ge_limit_o = (cnt_q >= LIMIT_C);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single-port data memory. CPU has fixed
// priority; the loader is aged so it wins after STARVE_LIMIT lost rounds.
// Each access runs IDLE -> ACCESS -> RESP; all memory-side outputs are
// registered, so requests never reach mem_* combinationally.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_cycle,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  arb_state_e        state_q, state_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        owner_q, owner_d;
  logic              is_wr_q, is_wr_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              ldr_ack_q, ldr_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
  logic              age_inc, age_clr, age_ge;
  logic              pick_ldr;

  arb_age_counter #(.LIMIT(STARVE_LIMIT)) u_age (
    .clk        (clk),
    .reset_cycle(reset_cycle),
    .inc_i      (age_inc),
    .clr_i      (age_clr),
    .ge_limit_o (age_ge)
  );

  // loader wins when alone, or when it has been passed over often enough
  assign pick_ldr = ldr_req & (~cpu_req | age_ge);

  // next-state, grant mux and response capture
  always_comb begin
    state_d     = state_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    owner_d     = owner_q;
    is_wr_d     = is_wr_q;
    cpu_ack_d   = 1'b0;
    ldr_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    age_inc     = 1'b0;
    age_clr     = 1'b0;
    case (state_q)
      S_ARB_IDLE: begin
        owner_d = OWN_NONE;
        age_clr = ~ldr_req;
        if (cpu_req | ldr_req) begin
          state_d  = S_ARB_ACCESS;
          mem_en_d = 1'b1;
          if (pick_ldr) begin
            mem_we_d    = ldr_we;
            mem_addr_d  = ldr_addr;
            mem_wdata_d = ldr_wdata;
            is_wr_d     = ldr_we;
            owner_d     = OWN_LDR;
            age_clr     = 1'b1;
          end else begin
            mem_we_d    = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            is_wr_d     = cpu_we;
            owner_d     = OWN_CPU;
            age_inc     = ldr_req;
          end
        end
      end
      S_ARB_ACCESS: begin
        // memory samples the access at this edge; ack shows during RESP
        state_d   = S_ARB_RESP;
        cpu_ack_d = (owner_q == OWN_CPU);
        ldr_ack_d = (owner_q == OWN_LDR);
      end
      S_ARB_RESP: begin
        state_d = S_ARB_IDLE;
        owner_d = OWN_NONE;
        if (!is_wr_q) begin
          if (cpu_ack_q) cpu_rdata_d = mem_rdata;
          if (ldr_ack_q) ldr_rdata_d = mem_rdata;
        end
      end
      default: begin
        state_d = S_ARB_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // state and output registers; async reset aborts any access in flight
  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      state_q     <= S_ARB_IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      owner_q     <= OWN_NONE;
      is_wr_q     <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      owner_q     <= owner_d;
      is_wr_q     <= is_wr_d;
      cpu_ack_q   <= cpu_ack_d;
      ldr_ack_q   <= ldr_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign owner     = owner_q;
  assign cpu_ack   = cpu_ack_q;
  assign ldr_ack   = ldr_ack_q;
  // memory read data arrives in the ack cycle; forward it so rdata is
  // valid with ack, then hold the captured copy afterwards
  assign cpu_rdata = (cpu_ack_q & ~is_wr_q) ? mem_rdata : cpu_rdata_q;
  assign ldr_rdata = (ldr_ack_q & ~is_wr_q) ? mem_rdata : ldr_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: cycle table for the basic CPU/loader
// sequences, hand-written corner cases, then random traffic checked
// against a transaction-level model.
module tb_dmem_port_arbiter;

  logic       clk = 1'b0;
  logic       reset_cycle;
  logic       cpu_req, cpu_we, ldr_req, ldr_we;
  logic [7:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
  logic [7:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;
  logic       cpu_ack, ldr_ack, mem_en, mem_we;
  logic [1:0] owner;

  int checks = 0;
  int errors = 0;

  // bench memory: synchronous single port, plus a preload port
  logic [7:0] mem [256];
  logic       pre_we = 1'b0;
  logic [7:0] pre_a = 8'h00, pre_d = 8'h00;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we)
      mem[pre_a] <= pre_d;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  dmem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_cycle(reset_cycle),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  typedef struct {
    logic       creq, cwe;
    logic [7:0] caddr, cwd;
    logic       lreq, lwe;
    logic [7:0] laddr, lwd;
    logic       en, we, cack, lack;
    logic [1:0] own;
    logic [7:0] crd, lrd;
  } vec_t;

  function automatic vec_t mk(
    input logic creq, input logic cwe, input logic [7:0] caddr, input logic [7:0] cwd,
    input logic lreq, input logic lwe, input logic [7:0] laddr, input logic [7:0] lwd,
    input logic en, input logic we, input logic cack, input logic lack,
    input logic [1:0] own, input logic [7:0] crd, input logic [7:0] lrd);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.lreq = lreq; v.lwe = lwe; v.laddr = laddr; v.lwd = lwd;
    v.en = en; v.we = we; v.cack = cack; v.lack = lack;
    v.own = own; v.crd = crd; v.lrd = lrd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    tick();
    pre_we = 1'b0;
  endtask

  // watchdog: the run is bounded by loop counts, this catches anything else
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  vec_t       tbl [9];
  logic [7:0] ref_mem [256];

  initial begin
    int acks, ens;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 8'h00; ldr_wdata = 8'h00;
    reset_cycle = 1'b1;
    #2;
    chk("reset mem_en", 32'(mem_en), 32'd0);
    chk("reset cpu_ack", 32'(cpu_ack), 32'd0);
    chk("reset owner", 32'(owner), 32'd0);
    chk("reset cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("reset ldr_rdata", 32'(ldr_rdata), 32'd0);
    preload(8'h10, 8'hA5);
    preload(8'h20, 8'h00);
    preload(8'h30, 8'h3C);
    reset_cycle = 1'b0;

    // table: inputs held across edge i, outputs expected just after it
    //             creq cwe   caddr  cwd    lreq lwe   laddr  lwd    en   we   cack lack own    crd    lrd
    tbl[0] = mk(1'b1,1'b0,8'h10,8'h00,1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,1'b0,1'b0,2'b01,8'h00,8'h00);
    tbl[1] = mk(1'b1,1'b0,8'h10,8'h00,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0,1'b1,1'b0,2'b01,8'hA5,8'h00);
    tbl[2] = mk(1'b0,1'b0,8'h00,8'h00,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0,1'b0,1'b0,2'b00,8'hA5,8'h00);
    tbl[3] = mk(1'b1,1'b1,8'h20,8'h11,1'b1,1'b0,8'h20,8'h00,1'b1,1'b1,1'b0,1'b0,2'b01,8'hA5,8'h00);
    tbl[4] = mk(1'b1,1'b1,8'h20,8'h11,1'b1,1'b0,8'h20,8'h00,1'b0,1'b0,1'b1,1'b0,2'b01,8'hA5,8'h00);
    tbl[5] = mk(1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,8'h20,8'h00,1'b0,1'b0,1'b0,1'b0,2'b00,8'hA5,8'h00);
    tbl[6] = mk(1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,8'h20,8'h00,1'b1,1'b0,1'b0,1'b0,2'b10,8'hA5,8'h00);
    tbl[7] = mk(1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,8'h20,8'h00,1'b0,1'b0,1'b0,1'b1,2'b10,8'hA5,8'h11);
    tbl[8] = mk(1'b0,1'b0,8'h00,8'h00,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0,1'b0,1'b0,2'b00,8'hA5,8'h11);

    for (int i = 0; i < 9; i++) begin
      cpu_req = tbl[i].creq; cpu_we = tbl[i].cwe; cpu_addr = tbl[i].caddr; cpu_wdata = tbl[i].cwd;
      ldr_req = tbl[i].lreq; ldr_we = tbl[i].lwe; ldr_addr = tbl[i].laddr; ldr_wdata = tbl[i].lwd;
      tick();
      chk($sformatf("row%0d mem_en", i), 32'(mem_en), 32'(tbl[i].en));
      chk($sformatf("row%0d mem_we", i), 32'(mem_we), 32'(tbl[i].we));
      chk($sformatf("row%0d cpu_ack", i), 32'(cpu_ack), 32'(tbl[i].cack));
      chk($sformatf("row%0d ldr_ack", i), 32'(ldr_ack), 32'(tbl[i].lack));
      chk($sformatf("row%0d owner", i), 32'(owner), 32'(tbl[i].own));
      chk($sformatf("row%0d cpu_rdata", i), 32'(cpu_rdata), 32'(tbl[i].crd));
      chk($sformatf("row%0d ldr_rdata", i), 32'(ldr_rdata), 32'(tbl[i].lrd));
    end

    // both held high: CPU wins four times, loader the fifth, then count restarts
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 8'h20;
    for (int a = 0; a < 10; a++) begin
      tick();
      chk($sformatf("starve arb%0d owner", a), 32'(owner), (a == 4 || a == 9) ? 32'd2 : 32'd1);
      chk($sformatf("starve arb%0d mem_en", a), 32'(mem_en), 32'd1);
      tick();
      tick();
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
    tick();

    // async reset during the ACCESS cycle of a write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 8'h77;
    tick();
    chk("abort pre mem_we", 32'(mem_we), 32'd1);
    #2 reset_cycle = 1'b1;
    #1;
    chk("abort mem_we", 32'(mem_we), 32'd0);
    chk("abort mem_en", 32'(mem_en), 32'd0);
    chk("abort owner", 32'(owner), 32'd0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    chk("abort mem30", 32'(mem[8'h30]), 32'h3C);
    reset_cycle = 1'b0;
    acks = 0; ens = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      acks += int'(cpu_ack); ens += int'(mem_en);
    end
    chk("abort no ack", 32'(acks), 32'd0);
    chk("abort no en", 32'(ens), 32'd0);

    // request dropped right after grant still completes once
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    tick();
    cpu_req = 1'b0;
    acks = 0; ens = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      acks += int'(cpu_ack); ens += int'(mem_en);
      if (cpu_ack) chk("drop rdata", 32'(cpu_rdata), 32'hA5);
    end
    chk("drop ack count", 32'(acks), 32'd1);
    chk("drop en count", 32'(ens), 32'd0);
    chk("drop owner", 32'(owner), 32'd0);

    // idle
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle bus", {28'd0, mem_en, cpu_ack, ldr_ack, |owner}, 32'd0);
    end

    // random traffic against a transaction-level model
    reset_cycle = 1'b1;
    for (int a = 8'h40; a < 8'h48; a++) begin
      ref_mem[a] = 8'($urandom);
      preload(8'(a), ref_mem[a]);
    end
    reset_cycle = 1'b0;
    begin
      int free_at = 0, cnt = 0, g_edge = -10;
      logic [1:0] g_who = 2'b00;
      logic g_we = 1'b0;
      logic [7:0] g_addr = 8'h00, g_wd = 8'h00, g_val = 8'h00;
      logic [7:0] exp_crd = 8'h00, exp_lrd = 8'h00;
      logic c_pend = 1'b0, c_drop = 1'b0, l_pend = 1'b0, l_drop = 1'b0;
      logic lwin, e_en, e_ca, e_la;
      for (int k = 0; k < 700; k++) begin
        if (c_drop) begin
          cpu_req = 1'b0; c_pend = 1'b0; c_drop = 1'b0;
        end else if (!c_pend && $urandom_range(0, 2) != 0) begin
          c_pend = 1'b1; cpu_req = 1'b1; cpu_we = 1'($urandom);
          cpu_addr = 8'(8'h40 + $urandom_range(0, 7)); cpu_wdata = 8'($urandom);
        end
        if (l_drop) begin
          ldr_req = 1'b0; l_pend = 1'b0; l_drop = 1'b0;
        end else if (!l_pend && $urandom_range(0, 2) != 0) begin
          l_pend = 1'b1; ldr_req = 1'b1; ldr_we = 1'($urandom);
          ldr_addr = 8'(8'h40 + $urandom_range(0, 7)); ldr_wdata = 8'($urandom);
        end
        // model: the port is free three edges after each grant
        if (k >= free_at) begin
          if (!ldr_req) cnt = 0;
          if (cpu_req || ldr_req) begin
            lwin = ldr_req && (!cpu_req || cnt >= 4);
            if (lwin) cnt = 0;
            else if (ldr_req) cnt = (cnt < 7) ? cnt + 1 : 7;
            g_edge = k; free_at = k + 3;
            g_who  = lwin ? 2'b10 : 2'b01;
            g_we   = lwin ? ldr_we : cpu_we;
            g_addr = lwin ? ldr_addr : cpu_addr;
            g_wd   = lwin ? ldr_wdata : cpu_wdata;
            if (g_we) ref_mem[g_addr] = g_wd;
            else      g_val = ref_mem[g_addr];
          end
        end
        tick();
        e_en = (k == g_edge);
        e_ca = (k == g_edge + 1) && (g_who == 2'b01);
        e_la = (k == g_edge + 1) && (g_who == 2'b10);
        if (e_ca && !g_we) exp_crd = g_val;
        if (e_la && !g_we) exp_lrd = g_val;
        chk("rnd mem_en", 32'(mem_en), 32'(e_en));
        chk("rnd mem_we", 32'(mem_we), 32'(e_en && g_we));
        chk("rnd owner", 32'(owner), (k == g_edge || k == g_edge + 1) ? 32'(g_who) : 32'd0);
        chk("rnd cpu_ack", 32'(cpu_ack), 32'(e_ca));
        chk("rnd ldr_ack", 32'(ldr_ack), 32'(e_la));
        chk("rnd cpu_rdata", 32'(cpu_rdata), 32'(exp_crd));
        chk("rnd ldr_rdata", 32'(ldr_rdata), 32'(exp_lrd));
        if (e_en) chk("rnd mem_addr", 32'(mem_addr), 32'(g_addr));
        if (e_en && g_we) chk("rnd mem_wdata", 32'(mem_wdata), 32'(g_wd));
        if (e_ca) c_drop = 1'b1;
        if (e_la) l_drop = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
